mult_div_unit: RTL and testbench

//   Iterative multiply/divide unit for the multi-cycle MIPS datapath; sits beside the ALU in the EX step.

---
 rtl/mult_div_unit.sv | 165 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// mult_div_unit : iterative 32-step MULT/MULTU/DIV/DIVU engine owning HI/LO
// Rev 1.0
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               div_zero_q, div_zero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // op[0]=0 selects the signed variants (MULT, DIV)
  assign a_neg = ~op[0] & A[WIDTH-1];
  assign b_neg = ~op[0] & B[WIDTH-1];
  assign mag_a = a_neg ? -A : A;
  assign mag_b = b_neg ? -B : B;

  // Multiply: acc holds {partial, multiplier}; add on LSB then shift right.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};

  // Divide: acc holds {rem, quot}; the shifted remainder is acc_q[2W-1:W-1].
  assign div_ge   = acc_q[2*WIDTH-1:WIDTH-1] >= {1'b0, opnd_q};
  assign div_diff = acc_q[2*WIDTH-2:WIDTH-1] - opnd_q;

  assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
  assign quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    is_div_d   = is_div_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    div_zero_d = div_zero_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d    = S_CALC;
          busy_d     = 1'b1;
          cnt_d      = '0;
          is_div_d   = op[1];
          sign_a_d   = a_neg;
          sign_b_d   = b_neg;
          div_zero_d = op[1] && (B == '0);
          opnd_d     = op[1] ? mag_b : mag_a;
          acc_d      = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          acc_d = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                         : {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == c_last_iter) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        // A zero divisor still runs the full sequence but leaves HI/LO alone.
        if (!div_zero_q) begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_div_q   <= is_div_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// tb_mult_div_unit : randomized self-checking bench with arithmetic reference
// Rev 1.0
// ============================================================================
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] HI, LO;

  logic [31:0] hi_m, lo_m;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(a), .B(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {HI,LO} as the ISA defines them, from plain 64-bit arithmetic
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    logic signed [63:0] sa, sb, q, r;
    logic        [63:0] ua, ub;
    sa = {{32{av[31]}}, av};
    sb = {{32{bv[31]}}, bv};
    ua = {32'h0, av};
    ub = {32'h0, bv};
    case (o)
      2'd0: return sa * sb;
      2'd1: return ua * ub;
      2'd2: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        q = ua / ub;
        r = ua % ub;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // restart_at / hiwe_at: busy cycle in which to inject a stray start / hi_we
  // (hiwe_at==0 means alongside the start itself, -1 means never)
  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input int restart_at, input int hiwe_at);
    logic [63:0] r;
    bit          busy_ok;
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    if (hiwe_at == 0) begin
      wdata = $urandom;
      hi_we = 1'b1;
      hi_m  = wdata;
    end
    busy_ok = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
      start = (c == restart_at);
      hi_we = (c == hiwe_at);
      wdata = $urandom;
      a     = $urandom;
      b     = $urandom;
      op    = 2'($urandom);
    end
    @(negedge clk);
    if (!(o[1] && bv == 32'h0)) begin
      r    = ref_result(o, av, bv);
      hi_m = r[63:32];
      lo_m = r[31:0];
    end
    check("busy_window", {63'h0, busy_ok}, 64'h1);
    check("done_pulse", {63'h0, done}, 64'h1);
    check("busy_at_done", {63'h0, busy}, 64'h0);
    check("HI", {32'h0, HI}, {32'h0, hi_m});
    check("LO", {32'h0, LO}, {32'h0, lo_m});
    @(negedge clk);
    check("done_single", {63'h0, done}, 64'h0);
  endtask

  task automatic write_hilo(input logic hw, input logic lw, input logic [31:0] d);
    @(negedge clk);
    hi_we = hw; lo_we = lw; wdata = d;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    if (hw) hi_m = d;
    if (lw) lo_m = d;
    check("mt_HI", {32'h0, HI}, {32'h0, hi_m});
    check("mt_LO", {32'h0, LO}, {32'h0, lo_m});
  endtask

  task automatic reset_mid_op();
    bit done_seen;
    @(negedge clk);
    op = 2'd2; a = $urandom; b = $urandom | 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    hi_m = 32'h0;
    lo_m = 32'h0;
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_HI", {32'h0, HI}, 64'h0);
    check("rst_LO", {32'h0, LO}, 64'h0);
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) done_seen = 1'b1;
    end
    check("rst_no_done", {63'h0, done_seen}, 64'h0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'd0; a = 32'h0; b = 32'h0; wdata = 32'h0;
    hi_m = 32'h0; lo_m = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    check("reset_HI", {32'h0, HI}, 64'h0);
    check("reset_LO", {32'h0, LO}, 64'h0);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    check("multu_max_const", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd5, -1, -1);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, -1, -1);
    run_op(2'd3, 32'd100, 32'd7, -1, -1);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, -1, -1);
    run_op(2'd2, 32'd7, 32'hFFFF_FFFE, -1, -1);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    check("div_ovf_const", {HI, LO}, 64'h0000_0000_8000_0000);

    write_hilo(1'b1, 1'b0, 32'h11);
    write_hilo(1'b0, 1'b1, 32'h22);
    run_op(2'd3, $urandom, 32'h0, -1, -1);
    check("divz_const", {HI, LO}, 64'h0000_0011_0000_0022);
    run_op(2'd2, $urandom, 32'h0, -1, -1);

    run_op(2'd1, $urandom, $urandom, 5, 10);
    run_op(2'd1, $urandom, $urandom, -1, 0);
    run_op(2'd3, $urandom, 32'h0, -1, 0);

    reset_mid_op();
    write_hilo(1'b0, 1'b1, 32'hCAFE_BABE);
    write_hilo(1'b1, 1'b1, $urandom);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1, 2:    rb = specials[$urandom_range(0, 4)];
        3:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 32)) : -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
